// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for the multi-channel debouncer.
//   state_t     : per-channel filter state (LOW, RISE_CHK, HIGH, FALL_CHK)
//   SYNC_STAGES : depth of the input synchroniser
// No ports. The optional long-press feature is enabled by DEBOUNCE_LONGPRESS_EN
// in the modules that import this package.
// -----------------------------------------------------------------------------
package debounce_pkg;

   localparam int unsigned SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      RISE_CHK = 2'd1,
      HIGH     = 2'd2,
      FALL_CHK = 2'd3
   } state_t;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debouncer channel: 2-FF synchroniser, stable-time filter FSM and
// one-cycle press/release pulses. With DEBOUNCE_LONGPRESS_EN defined a hold
// counter produces a single long_o pulse after LONG_CYCLES debounced-high cycles.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   button_in  in   raw asynchronous button level
//   button_out out  debounced level
//   press_o    out  1-cycle pulse on debounced 0->1
//   release_o  out  1-cycle pulse on debounced 1->0
//   long_o     out  1-cycle long-press pulse (DEBOUNCE_LONGPRESS_EN only)
// -----------------------------------------------------------------------------
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned LONG_CYCLES   = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic button_in,
   output logic button_out,
   output logic press_o,
   output logic release_o
`ifdef DEBOUNCE_LONGPRESS_EN
   ,
   output logic long_o
`endif
);

   localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES);

   logic [SYNC_STAGES-1:0] r_sync;
   state_t                 r_state;
   logic [CntW-1:0]        r_cnt;
   logic                   r_out;
   logic                   r_press;
   logic                   r_rel;

   logic            w_s;
   logic [CntW-1:0] w_cnt_inc;
   logic            w_rise_done;
   logic            w_fall_done;

   assign w_s         = r_sync[SYNC_STAGES-1];
   // Saturating increment: the counter never wraps back into a short count.
   assign w_cnt_inc   = (r_cnt == CntMax) ? r_cnt : r_cnt + CntW'(1);
   assign w_rise_done = (r_state == RISE_CHK) && w_s && (r_cnt >= CntLast);
   assign w_fall_done = (r_state == FALL_CHK) && !w_s && (r_cnt >= CntLast);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], button_in};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= LOW;
         r_cnt   <= '0;
         r_out   <= 1'b0;
         r_press <= 1'b0;
         r_rel   <= 1'b0;
      end else begin
         r_press <= 1'b0;
         r_rel   <= 1'b0;
         case (r_state)
            LOW: begin
               if (w_s) begin
                  r_state <= RISE_CHK;
                  r_cnt   <= CntW'(1);
               end else begin
                  r_cnt <= '0;
               end
            end
            RISE_CHK: begin
               if (!w_s) begin
                  r_state <= LOW;
                  r_cnt   <= '0;
               end else if (w_rise_done) begin
                  r_state <= HIGH;
                  r_cnt   <= '0;
                  r_out   <= 1'b1;
                  r_press <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            HIGH: begin
               if (!w_s) begin
                  r_state <= FALL_CHK;
                  r_cnt   <= CntW'(1);
               end else begin
                  r_cnt <= '0;
               end
            end
            FALL_CHK: begin
               if (w_s) begin
                  r_state <= HIGH;
                  r_cnt   <= '0;
               end else if (w_fall_done) begin
                  r_state <= LOW;
                  r_cnt   <= '0;
                  r_out   <= 1'b0;
                  r_rel   <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               r_state <= LOW;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign button_out = r_out;
   assign press_o    = r_press;
   assign release_o  = r_rel;

`ifdef DEBOUNCE_LONGPRESS_EN
   localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
   localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);

   logic [HoldW-1:0] r_hold;
   logic             r_long;

   // Hold counter sits at 0 in LOW/RISE_CHK so it starts from 0 on entry to HIGH;
   // FALL_CHK bounces that return to HIGH keep counting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold <= '0;
         r_long <= 1'b0;
      end else begin
         r_long <= 1'b0;
         if (r_state == LOW || r_state == RISE_CHK || w_fall_done) begin
            r_hold <= '0;
         end else if (r_hold != HoldMax) begin
            r_hold <= r_hold + HoldW'(1);
            if (r_hold == HoldLast) begin
               r_long <= 1'b1;
            end
         end
      end
   end

   assign long_o = r_long;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
// N-channel debouncer: CHANNELS independent debounce_channel instances whose
// outputs are concatenated bit-per-channel. Optional long-press output is
// enabled by defining DEBOUNCE_LONGPRESS_EN.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   button_in  in   [CHANNELS] raw asynchronous button levels
//   button_out out  [CHANNELS] debounced levels
//   press_o    out  [CHANNELS] 1-cycle pulse on debounced 0->1
//   release_o  out  [CHANNELS] 1-cycle pulse on debounced 1->0
//   long_o     out  [CHANNELS] 1-cycle long-press pulse (DEBOUNCE_LONGPRESS_EN only)
// -----------------------------------------------------------------------------
module multi_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned CHANNELS      = 4,
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned LONG_CYCLES   = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] button_in,
   output logic [CHANNELS-1:0] button_out,
   output logic [CHANNELS-1:0] press_o,
   output logic [CHANNELS-1:0] release_o
`ifdef DEBOUNCE_LONGPRESS_EN
   ,
   output logic [CHANNELS-1:0] long_o
`endif
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .LONG_CYCLES   (LONG_CYCLES)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .button_in  (button_in[g]),
         .button_out (button_out[g]),
         .press_o    (press_o[g]),
         .release_o  (release_o[g])
`ifdef DEBOUNCE_LONGPRESS_EN
         ,
         .long_o     (long_o[g])
`endif
      );
   end

endmodule
